// File: rtl/counter_seq_ctrl_pkg.sv
// Shared types and constants for the counter sequencing controller.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/counter_seq_ctrl_step.sv
// Loadable modulo-2^N up/down counter register; load has priority over enable.
module counter_step
    import counter_seq_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         en,
    input  logic         dir,
    output logic [N-1:0] q
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] q_d;
    logic [N-1:0] q_q;

    // NOTE: q_d gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (en) begin
            q_d = (dir == DIR_DOWN) ? q_q - ONE : q_q + ONE;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for an up/down counter: start/stop/pause, optional auto-reload.
// Define CNT_PINGPONG_EN (with AUTO_RELOAD=1) to bounce between start and end values.
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int N           = 3,
    parameter int AUTO_RELOAD = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic         dir,
    input  logic [N-1:0] start_val,
    input  logic [N-1:0] end_val,
    output logic [N-1:0] out,
    output logic         busy,
    output logic         done
);

    state_t       state_q, state_d;
    logic [N-1:0] start_q, start_d;
    logic [N-1:0] end_q, end_d;
    logic         dir_q, dir_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic         cnt_load;
    logic [N-1:0] cnt_load_val;
    logic         cnt_en;
    logic         cnt_dir;
    logic [N-1:0] cnt;
    logic         at_end;

    assign at_end = (cnt == end_q);

    counter_step #(.N(N)) u_step (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .dir      (cnt_dir),
        .q        (cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            start_q <= '0;
            end_q   <= '0;
            dir_q   <= DIR_UP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            end_q   <= end_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Priority in RUN: stop > terminal > pause > count.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start && !stop) state_d = RUN;
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (at_end) begin
                    if (AUTO_RELOAD == 0) state_d = IDLE;
                end else if (pause) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (stop) state_d = IDLE;
                else if (!pause) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_d      = start_q;
        end_d        = end_q;
        dir_d        = dir_q;
        done_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = start_q;
        cnt_en       = 1'b0;
        cnt_dir      = dir_q;
        busy_d       = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    start_d      = start_val;
                    end_d        = end_val;
                    dir_d        = dir;
                    cnt_load     = 1'b1;
                    cnt_load_val = start_val;
                end
            end
            RUN: begin
                if (!stop) begin
                    if (at_end) begin
                        done_d = 1'b1;
                        if (AUTO_RELOAD != 0) begin
`ifdef CNT_PINGPONG_EN
                            start_d = end_q;
                            end_d   = start_q;
                            dir_d   = ~dir_q;
                            cnt_dir = ~dir_q;
                            cnt_en  = (start_q != end_q);
`else
                            cnt_load = 1'b1;
`endif
                        end
                    end else if (!pause) begin
                        cnt_en = 1'b1;
                    end
                end
            end
            // Releasing pause counts on the same edge, so HOLD adds exactly one cycle per paused cycle.
            HOLD: if (!stop && !pause) cnt_en = 1'b1;
            default: ;
        endcase
    end

    assign out  = cnt;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench: one-shot instance (dut0) and auto-reload instance (dut1), N=3.
module tb_counter_seq_ctrl;

    typedef struct {
        int         w;
        logic [2:0] out;
        logic       busy;
        logic       done;
        string      nm;
    } exp_t;

    localparam logic [4:0] C_IDLE  = 5'b00000;
    localparam logic [4:0] C_RST   = 5'b10000;
    localparam logic [4:0] C_START = 5'b01000;
    localparam logic [4:0] C_STOP  = 5'b00100;
    localparam logic [4:0] C_PAUSE = 5'b00010;
    localparam logic [4:0] C_DOWN  = 5'b00001;

    logic       clk;
    logic       reset;
    logic       start0, stop0, pause0, dir0;
    logic       start1, stop1, pause1, dir1;
    logic [2:0] sv0, ev0, sv1, ev1;
    logic [2:0] out0, out1;
    logic       busy0, busy1, done0, done1;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    counter_seq_ctrl #(.N(3), .AUTO_RELOAD(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .stop(stop0), .pause(pause0),
        .dir(dir0), .start_val(sv0), .end_val(ev0), .out(out0), .busy(busy0), .done(done0)
    );

    counter_seq_ctrl #(.N(3), .AUTO_RELOAD(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .stop(stop1), .pause(pause1),
        .dir(dir1), .start_val(sv1), .end_val(ev1), .out(out1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Applies one cycle of stimulus to instance w and queues the state expected after the next edge.
    task automatic cyc(input int w, input logic [4:0] c, input logic [2:0] sv, input logic [2:0] ev,
                       input logic [2:0] eo, input logic eb, input logic ed, input string nm);
        exp_t e;
        @(negedge clk);
        #1;
        reset = c[4];
        {start0, stop0, pause0, dir0, sv0, ev0} = '0;
        {start1, stop1, pause1, dir1, sv1, ev1} = '0;
        if (w == 0) {start0, stop0, pause0, dir0, sv0, ev0} = {c[3:0], sv, ev};
        else        {start1, stop1, pause1, dir1, sv1, ev1} = {c[3:0], sv, ev};
        e.w = w; e.out = eo; e.busy = eb; e.done = ed; e.nm = nm;
        sb.push_back(e);
    endtask

    // Monitor: compares one queued expectation per cycle, sampled on the falling edge.
    initial begin
        exp_t       e;
        logic [2:0] a_out;
        logic       a_busy, a_done;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e      = sb.pop_front();
                a_out  = (e.w == 0) ? out0  : out1;
                a_busy = (e.w == 0) ? busy0 : busy1;
                a_done = (e.w == 0) ? done0 : done1;
                n_cmp++;
                if ({a_out, a_busy, a_done} !== {e.out, e.busy, e.done}) begin
                    n_bad++;
                    $display("FAIL %s (dut%0d): got out=%0d busy=%b done=%b, expected out=%0d busy=%b done=%b",
                             e.nm, e.w, a_out, a_busy, a_done, e.out, e.busy, e.done);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        {start0, stop0, pause0, dir0, sv0, ev0} = '0;
        {start1, stop1, pause1, dir1, sv1, ev1} = '0;

        // 1. reset and idle
        cyc(0, C_RST, 0, 0, 0, 0, 0, "t1_reset_a");
        cyc(1, C_RST, 0, 0, 0, 0, 0, "t1_reset_b");
        for (int i = 0; i < 3; i++) cyc(0, C_IDLE, 0, 0, 0, 0, 0, "t1_idle");

        // 2. up 2 -> 5
        cyc(0, C_START, 3'd2, 3'd5, 3'd2, 1, 0, "t2_load");
        for (int v = 3; v <= 5; v++) cyc(0, C_IDLE, 0, 0, 3'(v), 1, 0, "t2_count");
        cyc(0, C_IDLE, 0, 0, 3'd5, 0, 1, "t2_done");
        cyc(0, C_IDLE, 0, 0, 3'd5, 0, 0, "t2_after");

        // 3. down 1 -> 6 with wrap
        cyc(0, C_START | C_DOWN, 3'd1, 3'd6, 3'd1, 1, 0, "t3_load");
        cyc(0, C_IDLE, 0, 0, 3'd0, 1, 0, "t3_count0");
        cyc(0, C_IDLE, 0, 0, 3'd7, 1, 0, "t3_wrap7");
        cyc(0, C_IDLE, 0, 0, 3'd6, 1, 0, "t3_count6");
        cyc(0, C_IDLE, 0, 0, 3'd6, 0, 1, "t3_done");
        cyc(0, C_IDLE, 0, 0, 3'd6, 0, 0, "t3_after");

        // 4. up 0 -> 7 with a two-cycle pause at 3
        cyc(0, C_START, 3'd0, 3'd7, 3'd0, 1, 0, "t4_load");
        for (int v = 1; v <= 3; v++) cyc(0, C_IDLE, 0, 0, 3'(v), 1, 0, "t4_count");
        cyc(0, C_PAUSE, 0, 0, 3'd3, 1, 0, "t4_pause1");
        cyc(0, C_PAUSE, 0, 0, 3'd3, 1, 0, "t4_pause2");
        for (int v = 4; v <= 7; v++) cyc(0, C_IDLE, 0, 0, 3'(v), 1, 0, "t4_resume");
        cyc(0, C_IDLE, 0, 0, 3'd7, 0, 1, "t4_done");
        cyc(0, C_IDLE, 0, 0, 3'd7, 0, 0, "t4_after");

        // 5a. start while busy ignored, then stop at 4
        cyc(0, C_START, 3'd0, 3'd7, 3'd0, 1, 0, "t5_load");
        cyc(0, C_IDLE, 0, 0, 3'd1, 1, 0, "t5_count1");
        cyc(0, C_START | C_DOWN, 3'd5, 3'd1, 3'd2, 1, 0, "t5_start_ignored");
        cyc(0, C_IDLE, 0, 0, 3'd3, 1, 0, "t5_count3");
        cyc(0, C_IDLE, 0, 0, 3'd4, 1, 0, "t5_count4");
        cyc(0, C_STOP, 0, 0, 3'd4, 0, 0, "t5_stop");
        for (int i = 0; i < 2; i++) cyc(0, C_IDLE, 0, 0, 3'd4, 0, 0, "t5_no_done");

        // 5b. reset at 4
        cyc(0, C_START, 3'd0, 3'd7, 3'd0, 1, 0, "t5r_load");
        for (int v = 1; v <= 4; v++) cyc(0, C_IDLE, 0, 0, 3'(v), 1, 0, "t5r_count");
        cyc(0, C_RST, 0, 0, 3'd0, 0, 0, "t5r_reset");
        cyc(0, C_IDLE, 0, 0, 3'd0, 0, 0, "t5r_after");

        // start together with stop is not accepted; start_val == end_val finishes at once
        cyc(0, C_START | C_STOP, 3'd4, 3'd4, 3'd0, 0, 0, "start_with_stop");
        cyc(0, C_START, 3'd3, 3'd3, 3'd3, 1, 0, "eq_load");
        cyc(0, C_IDLE, 0, 0, 3'd3, 0, 1, "eq_done");
        cyc(0, C_IDLE, 0, 0, 3'd3, 0, 0, "eq_after");

        // 6. auto-reload 0 -> 2
        cyc(1, C_START, 3'd0, 3'd2, 3'd0, 1, 0, "t6_load");
`ifdef CNT_PINGPONG_EN
        cyc(1, C_IDLE, 0, 0, 3'd1, 1, 0, "t6_pp_1");
        cyc(1, C_IDLE, 0, 0, 3'd2, 1, 0, "t6_pp_2");
        cyc(1, C_IDLE, 0, 0, 3'd1, 1, 1, "t6_pp_turn_down");
        cyc(1, C_IDLE, 0, 0, 3'd0, 1, 0, "t6_pp_0");
        cyc(1, C_IDLE, 0, 0, 3'd1, 1, 1, "t6_pp_turn_up");
        cyc(1, C_IDLE, 0, 0, 3'd2, 1, 0, "t6_pp_2b");
        cyc(1, C_IDLE, 0, 0, 3'd1, 1, 1, "t6_pp_turn_down_b");
`else
        cyc(1, C_IDLE, 0, 0, 3'd1, 1, 0, "t6_ar_1");
        cyc(1, C_IDLE, 0, 0, 3'd2, 1, 0, "t6_ar_2");
        cyc(1, C_IDLE, 0, 0, 3'd0, 1, 1, "t6_ar_reload");
        cyc(1, C_IDLE, 0, 0, 3'd1, 1, 0, "t6_ar_1b");
        cyc(1, C_IDLE, 0, 0, 3'd2, 1, 0, "t6_ar_2b");
        cyc(1, C_IDLE, 0, 0, 3'd0, 1, 1, "t6_ar_reload_b");
        cyc(1, C_IDLE, 0, 0, 3'd1, 1, 0, "t6_ar_1c");
`endif
        cyc(1, C_STOP, 0, 0, 3'd1, 0, 0, "t6_stop");
        cyc(1, C_IDLE, 0, 0, 3'd1, 0, 0, "t6_after");

        repeat (2) @(negedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
